alu_ctrl_issue_stage: RTL
=========================

// Module: alu_ctrl_issue_stage
// PURPOSE
//   Producer side of the ALU control interface: decodes a RISC-V instruction into alu_control,
//   operands and control bits, and registers them into the ID/EX boundary for the ALU.
//   Valid/ready handshake on both sides, with a 2-entry skid buffer so in_ready is a register output.
//   Synchronous flush discards all buffered ops (branch mispredict / trap).
// PARAMETERS
//   XLEN          32  datapath width of pc, operands and immediates
//   DROP_ILLEGAL  0   1: illegal instructions are consumed, never issued; 0: issued with out_illegal=1
// PORTS
//   clk              in   1     single clock, rising edge
//   rst              in   1     asynchronous, active-low reset
//   flush            in   1     synchronous; empties buffer this cycle
//   in_valid         in   1     decode-side op valid
//   in_ready         out  1     stage can accept an op (registered)
//   in_instr         in   32    instruction word
//   in_pc            in   XLEN  instruction pc
//   in_rs1_data      in   XLEN  register file read port 1
//   in_rs2_data      in   XLEN  register file read port 2
//   out_valid        out  1     issued op valid toward ALU
//   out_ready        in   1     EX stage accepts op
//   out_alu_control  out  3     000 add, 001 sub, 010 and, 011 or, 101 slt
//   out_srca         out  XLEN  ALU operand A (rs1 data)
//   out_srcb         out  XLEN  ALU operand B (rs2 data or sign-extended immediate)
//   out_rs2_data     out  XLEN  store data
//   out_imm          out  XLEN  sign-extended immediate (B-type used as branch offset)
//   out_pc           out  XLEN  pc of issued op
//   out_rd           out  5     destination register
//   out_reg_write    out  1     op writes rd
//   out_mem_write    out  1     store
//   out_result_src   out  1     1 = load data, 0 = ALU result
//   out_branch       out  1     beq; EX takes branch on ALU zero
//   out_illegal      out  1     unsupported opcode/funct
// BEHAVIOUR
//   Decode (combinational, on in_instr):
//     0000011 lw   -> add,  srcb=I-imm, reg_write=1, result_src=1
//     0100011 sw   -> add,  srcb=S-imm, mem_write=1
//     1100011 beq  -> sub,  srcb=rs2,   branch=1, imm=B-imm (bit0=0)
//     0110011 R    -> funct3 000: add (sub if funct7[5]=1); 010 slt; 110 or; 111 and; srcb=rs2
//     0010011 I    -> same funct3 map, never sub; srcb=I-imm; reg_write=1 (also for R-type)
//     any other opcode/funct3, or funct7 not in {0000000,0100000} on R-type, or beq with funct3!=000
//       -> illegal=1, alu_control=000, reg_write=mem_write=branch=0
//     rd=0 forces reg_write=0.
//   Buffer: main slot M feeds outputs, skid slot S. States EMPTY, ONE (M valid), FULL (M,S valid).
//     EMPTY: accept -> ONE (M<=decoded).
//     ONE: accept & out_ready -> ONE (M replaced); accept & !out_ready -> FULL (S<=decoded);
//          !accept & out_ready -> EMPTY.
//     FULL: out_ready -> ONE (M<=S); in_ready=0, no accept.
//     accept = in_valid & in_ready (& !(DROP_ILLEGAL & illegal): dropped ops are still consumed).
//   in_ready = (state!=FULL), registered; out_valid = (state!=EMPTY).
//   Latency: op accepted in cycle N is visible on out_* in cycle N+1; throughput 1 op/cycle.
//   Order strictly preserved; output payload stable while out_valid & !out_ready.
//   flush: next state EMPTY regardless of in_valid/out_ready; an op offered the same cycle is
//     dropped (flush wins over accept); in_ready=1 next cycle.
//   Reset (rst=0, any time, incl. mid-transfer): state EMPTY, out_valid=0, in_ready=1 after release,
//     all out_* payload = 0.
//   Payload flops need no reset for correctness, but are reset to 0 so outputs are deterministic.
// TESTING
//   add x3,x1,x2 (0x002081B3), rs1=5, rs2=7, out_ready=1 -> next cycle out_alu_control=000, srca=5, srcb=7, rd=3
//   sub x3,x1,x2 (0x402081B3) -> out_alu_control=001; lw x5,-4(x2) -> 000, srcb=0xFFFFFFFC, result_src=1
//   out_ready=0, 3 back-to-back ops -> ops 1,2 buffered, in_ready=0 after 2nd; release -> issued 1,2,3 in order
//   beq x1,x2,-8 -> alu_control=001, branch=1, out_imm=0xFFFFFFF8, reg_write=0
//   Opcode 0x7F with DROP_ILLEGAL=0 -> out_illegal=1; with DROP_ILLEGAL=1 -> consumed, out_valid stays 0
//   FULL state + flush (and separately rst=0 mid-burst) -> out_valid=0 next cycle, in_ready=1, nothing issued

Source files
------------

// File: rtl/alu_ctrl_issue_stage.sv
// alu_ctrl_issue_stage: decodes an RV32 instruction into ALU control and operands and issues it
// through a 2-entry skid buffer so in_ready comes straight from a flop.
module alu_ctrl_issue_stage #(
  parameter int XLEN         = 32,
  parameter bit DROP_ILLEGAL = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2:0]      out_alu_control,
  output logic [XLEN-1:0] out_srca,
  output logic [XLEN-1:0] out_srcb,
  output logic [XLEN-1:0] out_rs2_data,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rd,
  output logic            out_reg_write,
  output logic            out_mem_write,
  output logic            out_result_src,
  output logic            out_branch,
  output logic            out_illegal
);
  typedef struct packed {
    logic [2:0]      alu_control;
    logic [XLEN-1:0] srca;
    logic [XLEN-1:0] srcb;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_write;
    logic            result_src;
    logic            branch;
    logic            illegal;
  } op_t;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t          state_q, state_d;
  op_t             m_q, m_d, s_q, s_d, dec;
  logic            in_ready_q;
  logic            load;
  logic [6:0]      opc, f7;
  logic [2:0]      f3, fmap;
  logic            fok;
  logic [XLEN-1:0] imm_i, imm_s, imm_b;
  logic            unused_rs1_field;
  assign opc   = in_instr[6:0];
  assign f3    = in_instr[14:12];
  assign f7    = in_instr[31:25];
  assign imm_i = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b = {{(XLEN-13){in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  // register indices are resolved upstream; only their data arrives here
  assign unused_rs1_field = ^in_instr[19:15];
  // shared funct3 map for R- and I-type: add, slt, or, and
  always_comb begin
    fok  = 1'b1;
    fmap = 3'b000;
    case (f3)
      3'b000:  fmap = 3'b000;
      3'b010:  fmap = 3'b101;
      3'b110:  fmap = 3'b011;
      3'b111:  fmap = 3'b010;
      default: fok  = 1'b0;
    endcase
  end
  always_comb begin
    dec          = '0;
    dec.srca     = in_rs1_data;
    dec.srcb     = in_rs2_data;
    dec.rs2_data = in_rs2_data;
    dec.pc       = in_pc;
    dec.rd       = in_instr[11:7];
    dec.illegal  = 1'b1;
    case (opc)
      7'b0000011: if (f3 == 3'b010) begin
        dec.illegal    = 1'b0;
        dec.srcb       = imm_i;
        dec.imm        = imm_i;
        dec.reg_write  = 1'b1;
        dec.result_src = 1'b1;
      end
      7'b0100011: if (f3 == 3'b010) begin
        dec.illegal   = 1'b0;
        dec.srcb      = imm_s;
        dec.imm       = imm_s;
        dec.mem_write = 1'b1;
      end
      7'b1100011: if (f3 == 3'b000) begin
        dec.illegal     = 1'b0;
        dec.alu_control = 3'b001;
        dec.imm         = imm_b;
        dec.branch      = 1'b1;
      end
      7'b0110011: if (fok && (f7 == 7'b0000000 || f7 == 7'b0100000)) begin
        dec.illegal     = 1'b0;
        dec.alu_control = (f3 == 3'b000 && f7[5]) ? 3'b001 : fmap;
        dec.reg_write   = 1'b1;
      end
      7'b0010011: if (fok) begin
        dec.illegal     = 1'b0;
        dec.alu_control = fmap;
        dec.srcb        = imm_i;
        dec.imm         = imm_i;
        dec.reg_write   = 1'b1;
      end
      default: ;
    endcase
    if (dec.rd == 5'd0) dec.reg_write = 1'b0;
  end
  // dropped illegal ops still complete the input handshake, they just never enter the buffer
  assign load = in_valid & in_ready_q & ~flush & ~(DROP_ILLEGAL & dec.illegal);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      m_q        <= '0;
      s_q        <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != FULL);
      m_q        <= m_d;
      s_q        <= s_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   state_d = load ? ONE : EMPTY;
      ONE:     state_d = (load && !out_ready) ? FULL : (!load && out_ready) ? EMPTY : ONE;
      FULL:    state_d = out_ready ? ONE : FULL;
      default: state_d = EMPTY;
    endcase
    if (flush) state_d = EMPTY;
  end
  always_comb begin
    m_d = (state_q == FULL) ? (out_ready ? s_q : m_q) :
          (load && (state_q == EMPTY || out_ready)) ? dec : m_q;
    s_d = (state_q == ONE && load && !out_ready) ? dec : s_q;
  end
  always_comb begin
    in_ready        = in_ready_q;
    out_valid       = (state_q != EMPTY);
    out_alu_control = m_q.alu_control;
    out_srca        = m_q.srca;
    out_srcb        = m_q.srcb;
    out_rs2_data    = m_q.rs2_data;
    out_imm         = m_q.imm;
    out_pc          = m_q.pc;
    out_rd          = m_q.rd;
    out_reg_write   = m_q.reg_write;
    out_mem_write   = m_q.mem_write;
    out_result_src  = m_q.result_src;
    out_branch      = m_q.branch;
    out_illegal     = m_q.illegal;
  end
endmodule
